dac_output_conditioner: RTL and testbench

//  Consumer of the composed DAC sample stream (24-bit signed sum + valid). Applies a

---
 rtl/dac_output_conditioner_pkg.sv | 43 ++++
 rtl/dac_output_conditioner_if.sv | 27 ++
 rtl/dac_output_conditioner_gain.sv | 80 ++++++++
 rtl/dac_output_conditioner.sv | 121 ++++++++++++
 tb/tb_dac_output_conditioner.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/dac_output_conditioner_pkg.sv
// Shared widths, state encoding and gain helpers for the DAC output conditioner.
package dac_output_conditioner_pkg;

    localparam int unsigned IN_W   = 24;
    localparam int unsigned OUT_W  = 14;
    localparam int unsigned G_W    = 17;
    localparam int unsigned GS_W   = G_W + 1;
    localparam int unsigned STEP_W = 16;
    localparam int unsigned LIM_W  = OUT_W - 1;
    localparam int unsigned CNT_W  = 16;
    // Full signed product width and the width that survives the >>> 16 scale-back
    localparam int unsigned PR_W   = IN_W + G_W + 1;
    localparam int unsigned P_W    = IN_W + G_W - 16;

    localparam logic [G_W-1:0]   GAIN_UNITY = {1'b1, {(G_W-1){1'b0}}};
    localparam logic [LIM_W-1:0] DAC_MAX    = LIM_W'(8191);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } ramp_state_e;

    // Gain after one upward step; a zero step jumps straight to unity.
    function automatic logic [G_W-1:0] gain_up(input logic [G_W-1:0] g,
                                               input logic [STEP_W-1:0] step);
        logic [GS_W-1:0] sum;
        sum = GS_W'(g) + GS_W'(step);
        if (step == '0 || sum >= GS_W'(GAIN_UNITY))
            return GAIN_UNITY;
        return sum[G_W-1:0];
    endfunction

    // Gain after one downward step; a zero step jumps straight to zero.
    function automatic logic [G_W-1:0] gain_down(input logic [G_W-1:0] g,
                                                 input logic [STEP_W-1:0] step);
        if (step == '0 || G_W'(step) >= g)
            return '0;
        return g - G_W'(step);
    endfunction

endpackage

// File: rtl/dac_output_conditioner_if.sv
// Sample stream, control and status bundle between the composer side and the conditioner.
interface dac_output_conditioner_if;
    import dac_output_conditioner_pkg::*;

    logic signed [IN_W-1:0]  signal_in;
    logic                    signal_valid;
    logic                    enable;
    logic [STEP_W-1:0]       ramp_step;
    logic [LIM_W-1:0]        limit;
    logic                    clip_clear;
    logic signed [OUT_W-1:0] dac_out;
    logic                    dac_valid;
    logic [1:0]              state;
    logic                    clip_flag;
    logic [CNT_W-1:0]        clip_count;

    modport master (
        output signal_in, signal_valid, enable, ramp_step, limit, clip_clear,
        input  dac_out, dac_valid, state, clip_flag, clip_count
    );

    modport slave (
        input  signal_in, signal_valid, enable, ramp_step, limit, clip_clear,
        output dac_out, dac_valid, state, clip_flag, clip_count
    );

endinterface

// File: rtl/dac_output_conditioner_gain.sv
// Soft-start/soft-stop envelope: ramp FSM plus the gain accumulator, advanced per valid sample.
module dac_gain_ramp
    import dac_output_conditioner_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              enable,
    input  logic [STEP_W-1:0] ramp_step,
    output logic [G_W-1:0]    gain,
    output ramp_state_e       state
);

    ramp_state_e      state_q, state_d;
    logic [G_W-1:0]   gain_q, gain_d;
    logic [G_W-1:0]   up_c, down_c;

    // State and gain registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    // Next state and gain; everything holds on cycles without a valid sample
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        up_c    = gain_up(gain_q, ramp_step);
        down_c  = gain_down(gain_q, ramp_step);
        if (advance) begin
            case (state_q)
                ST_IDLE: begin
                    gain_d = '0;
                    if (enable) begin
                        gain_d  = gain_up('0, ramp_step);
                        state_d = (gain_d == GAIN_UNITY) ? ST_RUN : ST_RAMP_UP;
                    end
                end
                ST_RAMP_UP: begin
                    if (enable) begin
                        gain_d  = up_c;
                        state_d = (up_c == GAIN_UNITY) ? ST_RUN : ST_RAMP_UP;
                    end else begin
                        gain_d  = down_c;
                        state_d = (down_c == '0) ? ST_IDLE : ST_RAMP_DOWN;
                    end
                end
                ST_RUN: begin
                    gain_d = GAIN_UNITY;
                    if (!enable) begin
                        gain_d  = gain_down(GAIN_UNITY, ramp_step);
                        state_d = (gain_d == '0) ? ST_IDLE : ST_RAMP_DOWN;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (enable) begin
                        gain_d  = up_c;
                        state_d = (up_c == GAIN_UNITY) ? ST_RUN : ST_RAMP_UP;
                    end else begin
                        gain_d  = down_c;
                        state_d = (down_c == '0) ? ST_IDLE : ST_RAMP_DOWN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gain_d  = '0;
                end
            endcase
        end
    end

    assign gain  = gain_q;
    assign state = state_q;

endmodule

// File: rtl/dac_output_conditioner.sv
// Gain envelope, scale and symmetric clamp from the composed sample stream to the DAC code.
module dac_output_conditioner
    import dac_output_conditioner_pkg::*;
(
    input  logic clk,
    input  logic rst,
    dac_output_conditioner_if.slave bus
);

    logic [G_W-1:0]          gain;
    ramp_state_e             ramp_state;

    logic                    s1_valid;
    logic signed [IN_W-1:0]  s1_sample;
    logic [G_W-1:0]          s1_gain;
    logic                    s2_valid;
    logic signed [P_W-1:0]   s2_prod;

    logic signed [PR_W-1:0]  full_prod_c;
    logic [LIM_W-1:0]        lim_c;
    logic signed [P_W-1:0]   pos_lim_c;
    logic signed [P_W-1:0]   neg_lim_c;
    logic signed [P_W-1:0]   clamp_c;
    logic                    clip_c;

    logic signed [OUT_W-1:0] dac_out_q;
    logic                    dac_valid_q;
    logic                    clip_flag_q;
    logic [CNT_W-1:0]        clip_count_q;

    dac_gain_ramp u_gain_ramp (
        .clk       (clk),
        .rst       (rst),
        .advance   (bus.signal_valid),
        .enable    (bus.enable),
        .ramp_step (bus.ramp_step),
        .gain      (gain),
        .state     (ramp_state)
    );

    // S1: capture sample with the gain held before this cycle's update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_gain   <= '0;
        end else begin
            s1_valid  <= bus.signal_valid;
            s1_sample <= bus.signal_in;
            s1_gain   <= gain;
        end
    end

    // Signed scale; the arithmetic shift floors toward -inf
    always_comb begin
        full_prod_c = PR_W'(s1_sample) * PR_W'($signed({1'b0, s1_gain}));
    end

    // S2: scaled product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_prod  <= P_W'(full_prod_c >>> 16);
        end
    end

    // Symmetric clamp against the live limit, capped at the DAC full scale
    always_comb begin
        lim_c     = (bus.limit > DAC_MAX) ? DAC_MAX : bus.limit;
        pos_lim_c = $signed(P_W'(lim_c));
        neg_lim_c = -pos_lim_c;
        clamp_c   = s2_prod;
        clip_c    = 1'b0;
        if (s2_prod > pos_lim_c) begin
            clamp_c = pos_lim_c;
            clip_c  = s2_valid;
        end else if (s2_prod < neg_lim_c) begin
            clamp_c = neg_lim_c;
            clip_c  = s2_valid;
        end
    end

    // S3: DAC code holds between valid samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_out_q   <= '0;
            dac_valid_q <= 1'b0;
        end else begin
            dac_valid_q <= s2_valid;
            if (s2_valid)
                dac_out_q <= OUT_W'(clamp_c);
        end
    end

    // Clip status; a clip in the same cycle as a clear restarts the count at one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_flag_q  <= 1'b0;
            clip_count_q <= '0;
        end else if (clip_c) begin
            clip_flag_q <= 1'b1;
            if (bus.clip_clear)
                clip_count_q <= CNT_W'(1);
            else if (clip_count_q != '1)
                clip_count_q <= clip_count_q + CNT_W'(1);
        end else if (bus.clip_clear) begin
            clip_flag_q  <= 1'b0;
            clip_count_q <= '0;
        end
    end

    assign bus.dac_out    = dac_out_q;
    assign bus.dac_valid  = dac_valid_q;
    assign bus.state      = ramp_state;
    assign bus.clip_flag  = clip_flag_q;
    assign bus.clip_count = clip_count_q;

endmodule

// File: tb/tb_dac_output_conditioner.sv
// Bench for dac_output_conditioner: directed scenarios plus random traffic against a gain/clip model.
module tb_dac_output_conditioner;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dac_output_conditioner_if bus();

    dac_output_conditioner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: gain as a plain integer, samples carried with the gain they saw
    longint g_m;
    int     st_m;
    bit     pv[2];
    longint px[2];
    longint pg[2];
    longint out_m;
    bit     vout_m;
    bit     flag_m;
    longint cnt_m;

    function automatic void model_reset();
        g_m = 0; st_m = 0; out_m = 0; vout_m = 0; flag_m = 0; cnt_m = 0;
        for (int i = 0; i < 2; i++) begin
            pv[i] = 0; px[i] = 0; pg[i] = 0;
        end
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dac_valid"},  longint'(bus.dac_valid), longint'(vout_m));
        chk({tag, ".dac_out"},    longint'(bus.dac_out), out_m);
        chk({tag, ".state"},      longint'(bus.state), longint'(st_m));
        chk({tag, ".clip_flag"},  longint'(bus.clip_flag), longint'(flag_m));
        chk({tag, ".clip_count"}, longint'(bus.clip_count), cnt_m);
    endtask

    // One clock: advance the model with the inputs currently driven, then compare
    task automatic tick(input bit do_check);
        longint p, lim, x, stp;
        bit     clip;
        clip = 0;
        lim  = longint'(bus.limit);
        if (lim > 8191) lim = 8191;
        vout_m = pv[1];
        if (pv[1]) begin
            p = (px[1] * pg[1]) >>> 16;
            if (p > lim) begin
                out_m = lim; clip = 1;
            end else if (p < -lim) begin
                out_m = -lim; clip = 1;
            end else begin
                out_m = p;
            end
        end
        if (clip) begin
            flag_m = 1;
            if (bus.clip_clear) cnt_m = 1;
            else if (cnt_m < 65535) cnt_m = cnt_m + 1;
        end else if (bus.clip_clear) begin
            flag_m = 0; cnt_m = 0;
        end
        x   = longint'(bus.signal_in);
        stp = longint'(bus.ramp_step);
        pv[1] = pv[0]; px[1] = px[0]; pg[1] = pg[0];
        pv[0] = bus.signal_valid; px[0] = x; pg[0] = g_m;
        if (bus.signal_valid) begin
            if (bus.enable) begin
                g_m  = (stp == 0 || g_m + stp >= 65536) ? 65536 : g_m + stp;
                st_m = (g_m == 65536) ? 2 : 1;
            end else begin
                g_m  = (stp == 0 || g_m - stp <= 0) ? 0 : g_m - stp;
                st_m = (g_m == 0) ? 0 : 3;
            end
        end
        @(posedge clk);
        #1;
        if (do_check) chk_all("cyc");
    endtask

    initial begin
        rst              = 1'b1;
        bus.signal_in    = '0;
        bus.signal_valid = 1'b0;
        bus.enable       = 1'b0;
        bus.ramp_step    = 16'd16384;
        bus.limit        = 13'd8191;
        bus.clip_clear   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        rst = 1'b0;

        // Disabled: valid samples flow but carry zero gain
        bus.signal_valid = 1'b1;
        bus.signal_in    = 24'sd1000;
        repeat (6) tick(1'b1);
        chk("idle_out", longint'(bus.dac_out), 0);
        chk("idle_state", longint'(bus.state), 0);

        // Soft start in quarter steps
        bus.enable    = 1'b1;
        bus.signal_in = 24'sd4000;
        repeat (8) tick(1'b1);
        chk("ramp_final_out", longint'(bus.dac_out), 4000);
        chk("ramp_final_state", longint'(bus.state), 2);

        // Negative overdrive against a programmed limit, then full scale
        bus.signal_in = -24'sd20000;
        bus.limit     = 13'd5000;
        repeat (5) tick(1'b1);
        chk("clip_neg_out", longint'(bus.dac_out), -5000);
        chk("clip_neg_flag", longint'(bus.clip_flag), 1);
        bus.limit = 13'd8191;
        repeat (4) tick(1'b1);
        chk("clip_fullscale_out", longint'(bus.dac_out), -8191);

        // Clear coincident with a clip restarts at one
        bus.clip_clear = 1'b1;
        tick(1'b1);
        bus.clip_clear = 1'b0;
        chk("clear_coincident", longint'(bus.clip_count), 1);

        // Drain the pipe, then a clear with no clip
        bus.signal_valid = 1'b0;
        repeat (3) tick(1'b1);
        bus.clip_clear = 1'b1;
        tick(1'b1);
        bus.clip_clear = 1'b0;
        chk("clear_alone_count", longint'(bus.clip_count), 0);
        chk("clear_alone_flag", longint'(bus.clip_flag), 0);

        // Abort a ramp-up at half gain
        bus.signal_valid = 1'b1;
        bus.signal_in    = 24'sd4000;
        bus.enable       = 1'b0;
        bus.ramp_step    = 16'd0;
        tick(1'b1);
        bus.enable    = 1'b1;
        bus.ramp_step = 16'd16384;
        repeat (2) tick(1'b1);
        chk("half_gain_state", longint'(bus.state), 1);
        bus.enable = 1'b0;
        repeat (6) tick(1'b1);
        chk("ramp_down_done", longint'(bus.state), 0);

        // Zero step jumps, and gaps in valid freeze the FSM
        bus.ramp_step    = 16'd0;
        bus.enable       = 1'b1;
        bus.signal_valid = 1'b0;
        repeat (3) tick(1'b1);
        chk("gap_hold_idle", longint'(bus.state), 0);
        bus.signal_valid = 1'b1;
        tick(1'b1);
        chk("jump_run", longint'(bus.state), 2);
        bus.signal_valid = 1'b0;
        bus.enable       = 1'b0;
        repeat (2) tick(1'b1);
        chk("gap_hold_run", longint'(bus.state), 2);
        bus.signal_valid = 1'b1;
        tick(1'b1);
        chk("jump_idle", longint'(bus.state), 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.signal_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) bus.enable = ~bus.enable;
            bus.ramp_step  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40000));
            bus.signal_in  = 24'($urandom);
            bus.limit      = 13'($urandom);
            bus.clip_clear = ($urandom_range(0, 9) == 0);
            tick(1'b1);
        end
        bus.clip_clear = 1'b0;

        // Clip counter saturation
        bus.signal_valid = 1'b1;
        bus.enable       = 1'b1;
        bus.ramp_step    = 16'd0;
        bus.signal_in    = -24'sd20000;
        bus.limit        = 13'd100;
        bus.clip_clear   = 1'b1;
        tick(1'b1);
        bus.clip_clear = 1'b0;
        for (int i = 0; i < 65540; i++) tick(1'b0);
        chk_all("sat");
        chk("sat_count", longint'(bus.clip_count), 65535);

        // Asynchronous reset in the middle of a ramp
        bus.enable    = 1'b0;
        tick(1'b1);
        repeat (3) tick(1'b1);
        bus.enable    = 1'b1;
        bus.ramp_step = 16'd1000;
        bus.signal_in = 24'sd5000;
        bus.limit     = 13'd8191;
        repeat (12) tick(1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("async_rst");
        chk("async_rst_dac_out", longint'(bus.dac_out), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) tick(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
